// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between byte-stream
// requesters, with packet lock and a mid-packet stall watchdog.
module uart_tx_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int STALL_MAX = 1000,
    localparam int GW       = $clog2(NUM_REQ),
    localparam int CW       = $clog2(STALL_MAX + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      tx_busy,
    output logic                      tx_start,
    output logic [DATA_W-1:0]         tx_data,
    output logic [GW-1:0]             grant_id,
    output logic                      active,
    output logic                      stall_err
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    localparam logic [GW:0] NR = (GW + 1)'(NUM_REQ);

    state_t              state;
    logic [GW-1:0]       rr_ptr;
    logic [CW-1:0]       cnt;
    logic                last_flag;

    logic [GW:0]         idx;
    logic [GW-1:0]       win;
    logic                found;
    logic                sel_valid;
    logic                sel_last;
    logic [DATA_W-1:0]   sel_data;

    // First valid requester after the last holder, wrapping around.
    always_comb begin
        idx   = '0;
        win   = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = {1'b0, rr_ptr} + (GW + 1)'(k);
            if (idx >= NR) idx = idx - NR;
            if (!found && req_valid[idx[GW-1:0]]) begin
                found = 1'b1;
                win   = idx[GW-1:0];
            end
        end
    end

    assign sel_valid = req_valid[grant_id];
    assign sel_last  = req_last[grant_id];
    assign sel_data  = req_data[grant_id*DATA_W +: DATA_W];

    always_comb begin
        req_ready = '0;
        if (state == LOAD) req_ready[grant_id] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            rr_ptr    <= GW'(NUM_REQ - 1);
            cnt       <= '0;
            last_flag <= 1'b0;
            tx_start  <= 1'b0;
            tx_data   <= '0;
            grant_id  <= '0;
            active    <= 1'b0;
            stall_err <= 1'b0;
        end else begin
            tx_start  <= 1'b0;
            stall_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (found && !tx_busy) begin
                        grant_id <= win;
                        active   <= 1'b1;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    if (sel_valid) begin
                        tx_data   <= sel_data;
                        last_flag <= sel_last;
                        tx_start  <= 1'b1;
                        cnt       <= '0;
                        state     <= WAIT_BUSY;
                    end else if (cnt == CW'(STALL_MAX - 1)) begin
                        stall_err <= 1'b1;
                        rr_ptr    <= grant_id;
                        active    <= 1'b0;
                        cnt       <= '0;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_BUSY: begin
                    if (tx_busy) state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        if (last_flag) begin
                            rr_ptr <= grant_id;
                            active <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: packet-level round-robin model,
// randomized packets, transmitter model, watchdog and reset checks.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int SM = 16;

    logic          clk;
    logic          reset;
    logic [N-1:0]  req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]  req_last;
    logic [N-1:0]  req_ready;
    logic          tx_busy;
    logic          tx_start;
    logic [DW-1:0] tx_data;
    logic [1:0]    grant_id;
    logic          active;
    logic          stall_err;

    uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(DW), .STALL_MAX(SM)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready),
        .tx_busy(tx_busy), .tx_start(tx_start),
        .tx_data(tx_data), .grant_id(grant_id),
        .active(active), .stall_err(stall_err)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int starts = 0;
    int stalls = 0;

    // driver queues, model queues, scoreboard
    logic [7:0] dq_d[N][$];
    bit         dq_l[N][$];
    logic [7:0] mbytes[N][$];
    int         mlen[N][$];
    int         sb_id[$];
    logic [7:0] sb_d[$];
    int         m_rr = N - 1;

    logic mbusy = 0;
    logic ext_busy = 0;
    assign tx_busy = mbusy | ext_busy;

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic check(string nm, longint act, longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic add_pkt(int r, int len, int base, bit rnd, bit abandon);
        logic [7:0] b;
        for (int j = 0; j < len; j++) begin
            b = rnd ? 8'($urandom) : 8'(base + j);
            dq_d[r].push_back(b);
            dq_l[r].push_back(!abandon && j == len - 1);
            mbytes[r].push_back(b);
        end
        mlen[r].push_back(len);
    endtask

    // Whole packets granted in round-robin order after the last holder.
    task automatic run_model();
        int f, len;
        while (1) begin
            f = -1;
            for (int k = 1; k <= N; k++)
                if (f < 0 && mlen[(m_rr + k) % N].size() > 0) f = (m_rr + k) % N;
            if (f < 0) break;
            len = mlen[f].pop_front();
            repeat (len) begin
                sb_id.push_back(f);
                sb_d.push_back(mbytes[f].pop_front());
            end
            m_rr = f;
        end
    endtask

    function automatic bit all_empty();
        bit e = 1;
        for (int i = 0; i < N; i++) if (dq_d[i].size() != 0) e = 0;
        return e;
    endfunction

    task automatic wait_drain(string nm);
        int t = 0;
        bit done = 0;
        while (!done && t < 4000) begin
            @(negedge clk);
            t++;
            done = sb_id.size() == 0 && all_empty() && !active && !tx_busy;
        end
        check(nm, done, 1);
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic check_reset_vals(string nm);
        check({nm, "_ready"}, req_ready, 0);
        check({nm, "_start"}, tx_start, 0);
        check({nm, "_data"}, tx_data, 0);
        check({nm, "_gid"}, grant_id, 0);
        check({nm, "_active"}, active, 0);
        check({nm, "_stall"}, stall_err, 0);
    endtask

    task automatic flush();
        for (int i = 0; i < N; i++) begin
            dq_d[i].delete(); dq_l[i].delete();
            mbytes[i].delete(); mlen[i].delete();
        end
        sb_id.delete(); sb_d.delete();
        m_rr = N - 1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 reset = 0;
        flush();
        repeat (2) @(negedge clk);
        reset = 1;
        repeat (2) @(negedge clk);
        #1;
    endtask

    // requester drivers
    int  gap[N];
    bit  acc[N];
    initial begin
        req_valid = '0; req_data = '0; req_last = '0;
        for (int i = 0; i < N; i++) begin gap[i] = 0; acc[i] = 0; end
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (!reset) begin
                    acc[i] = 0; gap[i] = 0; req_valid[i] = 0;
                end else begin
                    if (acc[i]) begin
                        void'(dq_d[i].pop_front());
                        void'(dq_l[i].pop_front());
                        gap[i] = $urandom_range(0, 3);
                        acc[i] = 0;
                    end
                    if (gap[i] > 0) begin
                        gap[i]--;
                        req_valid[i] = 0;
                    end else if (dq_d[i].size() > 0) begin
                        req_valid[i] = 1;
                        req_data[i*DW +: DW] = dq_d[i][0];
                        req_last[i] = dq_l[i][0];
                    end else begin
                        req_valid[i] = 0;
                    end
                    acc[i] = req_valid[i] & req_ready[i];
                end
            end
        end
    end

    // transmitter model: busy starts 0-1 cycles after start
    initial begin
        int left = 0, pend = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                left = 0; pend = 0;
            end else begin
                if (left > 0) left--;
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) left = $urandom_range(6, 20);
                end
                if (tx_start) begin
                    check("start_while_busy", (left > 0 || pend > 0), 0);
                    if ($urandom_range(0, 1) == 0) left = $urandom_range(6, 20);
                    else pend = 1;
                end
            end
            mbusy = (left > 0);
        end
    end

    // monitor
    initial begin
        int run = 0, last_run = 0, eid;
        logic [7:0] ed;
        logic [N-1:0] oh;
        forever begin
            @(negedge clk);
            if (!reset) begin
                run = 0; last_run = 0;
            end else begin
                if (req_ready != 0) begin
                    run++;
                    oh = '0; oh[grant_id] = 1'b1;
                    check("ready_onehot", req_ready, oh);
                end else if (run > 0) begin
                    last_run = run; run = 0;
                end
                if (tx_start) begin
                    starts++;
                    if (sb_id.size() == 0) begin
                        check("unexpected_start", 1, 0);
                    end else begin
                        eid = sb_id.pop_front();
                        ed = sb_d.pop_front();
                        check("grant_id", grant_id, eid);
                        check("tx_data", tx_data, ed);
                    end
                end
                if (stall_err) begin
                    stalls++;
                    check("stall_delay", last_run, SM);
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int s0, t, tot;
        reset = 0;
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        reset = 1;
        repeat (2) @(negedge clk);
        #1;

        // single requester, three bytes
        s0 = starts;
        add_pkt(0, 3, 'h41, 0, 0);
        run_model();
        wait_drain("drain_single");
        check("single_starts", starts - s0, 3);
        check("single_active", active, 0);
        check("single_gid", grant_id, 0);

        // round robin 1,2,1,2
        add_pkt(1, 1, 0, 1, 0); add_pkt(1, 1, 0, 1, 0);
        add_pkt(2, 1, 0, 1, 0); add_pkt(2, 1, 0, 1, 0);
        run_model();
        wait_drain("drain_rr12");

        // all four after reset: 0,1,2,3,0
        do_reset();
        add_pkt(0, 1, 0, 1, 0); add_pkt(0, 1, 0, 1, 0);
        for (int i = 1; i < N; i++) add_pkt(i, 1, 0, 1, 0);
        run_model();
        wait_drain("drain_rr_all");

        // packet lock: req 0 four bytes, req 3 waits with 0x55
        add_pkt(0, 4, 0, 1, 0);
        add_pkt(3, 1, 'h55, 0, 0);
        run_model();
        wait_drain("drain_lock");

        // watchdog: req 1 abandons after one byte, req 2 pending
        s0 = stalls;
        add_pkt(1, 1, 0, 1, 1);
        add_pkt(2, 2, 0, 1, 0);
        run_model();
        wait_drain("drain_stall");
        check("stall_count", stalls - s0, 1);

        // reset during WAIT_DONE of byte 2 of 3
        s0 = starts;
        add_pkt(0, 3, 'hA0, 0, 0);
        run_model();
        t = 0;
        while (starts < s0 + 2 && t < 200) begin @(negedge clk); t++; end
        check("rst_reach_b2", starts - s0, 2);
        t = 0;
        while (!tx_busy && t < 5) begin @(negedge clk); t++; end
        @(negedge clk);
        #2 reset = 0;
        #1 check_reset_vals("rst_mid");
        flush();
        repeat (2) @(negedge clk);
        reset = 1;
        s0 = starts;
        repeat (12) @(negedge clk);
        check("rst_no_start", starts - s0, 0);
        check("rst_idle", active, 0);
        #1;
        add_pkt(2, 1, 0, 1, 0);
        add_pkt(0, 2, 0, 1, 0);
        run_model();
        wait_drain("drain_after_rst");

        // external busy holds arbitration off
        ext_busy = 1;
        add_pkt(0, 1, 0, 1, 0);
        run_model();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("busy_ready", req_ready, 0);
            check("busy_active", active, 0);
        end
        @(negedge clk);
        ext_busy = 0;
        @(negedge clk);
        check("busy_grant_active", active, 1);
        check("busy_grant_ready", req_ready, 4'b0001);
        wait_drain("drain_busy");

        // randomized rounds
        for (int r = 0; r < 10; r++) begin
            tot = 0;
            for (int i = 0; i < N; i++) begin
                int np = $urandom_range(0, 2);
                for (int p = 0; p < np; p++) begin
                    add_pkt(i, $urandom_range(1, 4), 0, 1, 0);
                    tot++;
                end
            end
            if (tot == 0) add_pkt($urandom_range(0, N - 1), 2, 0, 1, 0);
            run_model();
            wait_drain("drain_rand");
        end
        check("total_stalls", stalls, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
